// File: rtl/ahb_slave_ctrl_if.sv
// AHB-Lite address-phase inputs and data-path strobes for the cipher slave control stage.
interface ahb_slave_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic        core_busy;
  logic        writek_enable;
  logic        writed_enable;
  logic        readd_enable;
  logic        hresp_error;
  logic        hready_enable;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, core_busy,
    output writek_enable, writed_enable, readd_enable, hresp_error, hready_enable
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, core_busy,
    input  writek_enable, writed_enable, readd_enable, hresp_error, hready_enable
  );
endinterface

// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite slave control FSM: decodes the address phase and sequences data-phase strobes
// (key/data writes, waited result read, two-cycle ERROR) for the AHB data-path block.
module ahb_slave_ctrl #(
  parameter int         RD_WAIT  = 2,
  parameter logic [7:0] KEY_OFS  = 8'h00,
  parameter logic [7:0] DIN_OFS  = 8'h10,
  parameter logic [7:0] DOUT_OFS = 8'h20
) (
  input logic               clk,
  input logic               n_rst,
  ahb_slave_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, WR_KEY, WR_DATA, RD_WAIT_S, RD_DONE, ERR1, ERR2
  } state_e;

  localparam int         RD_LOAD_I = (RD_WAIT > 0) ? RD_WAIT - 1 : 0;
  localparam logic [3:0] RD_LOAD   = 4'(RD_LOAD_I);

  state_e     state_q, state_d;
  state_e     dec_state;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;
  logic       writek, writed, readd, herr, hrdy;

  // Decode straight from the address phase; registering the decoded state
  // carries the sampled HWRITE/offset/HSIZE into the data phase.
  always_comb begin
    dec_state = ERR1;
    if (bus.HSIZE == 3'b100) begin
      if (bus.HWRITE && bus.HADDR[7:0] == KEY_OFS)
        dec_state = WR_KEY;
      else if (bus.HWRITE && bus.HADDR[7:0] == DIN_OFS)
        dec_state = WR_DATA;
      else if (!bus.HWRITE && bus.HADDR[7:0] == DOUT_OFS)
        dec_state = (RD_WAIT == 0) ? RD_DONE : RD_WAIT_S;
    end
  end

  always_comb begin
    writek = 1'b0;
    writed = 1'b0;
    readd  = 1'b0;
    herr   = 1'b0;
    hrdy   = 1'b0;
    unique case (state_q)
      IDLE:      hrdy = 1'b1;
      WR_KEY:    begin writek = 1'b1; hrdy = 1'b1; end
      WR_DATA:   begin writed = 1'b1; hrdy = !bus.core_busy; end
      RD_WAIT_S: readd = 1'b1;
      RD_DONE:   begin readd = 1'b1; hrdy = 1'b1; end
      ERR1:      herr = 1'b1;
      ERR2:      begin herr = 1'b1; hrdy = 1'b1; end
      default:   hrdy = 1'b1;
    endcase
  end

  // A held address phase is never taken while this slave is stalling the bus.
  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hrdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RD_WAIT_S) begin
      if (cnt_q == 4'd0) state_d = RD_DONE;
      else               cnt_d   = cnt_q - 4'd1;
    end else if (state_q == ERR1) begin
      state_d = ERR2;
    end else if (state_q == WR_DATA && bus.core_busy) begin
      state_d = WR_DATA;
    end else if (accept) begin
      state_d = dec_state;
      if (dec_state == RD_WAIT_S) cnt_d = RD_LOAD;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.writek_enable = writek;
  assign bus.writed_enable = writed;
  assign bus.readd_enable  = readd;
  assign bus.hresp_error   = herr;
  assign bus.hready_enable = hrdy;

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Scoreboard bench: stimulus pushes per-cycle expected strobes, a negedge monitor pops and compares.
module tb_ahb_slave_ctrl;
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  // {writek, writed, readd, hresp, hready}
  localparam logic [4:0] IDL = 5'b00001;
  localparam logic [4:0] WK  = 5'b10001;
  localparam logic [4:0] WD  = 5'b01001;
  localparam logic [4:0] WDS = 5'b01000;
  localparam logic [4:0] RW  = 5'b00100;
  localparam logic [4:0] RD  = 5'b00101;
  localparam logic [4:0] E1  = 5'b00010;
  localparam logic [4:0] E2  = 5'b00011;
  localparam logic [1:0] N   = 2'b10;
  localparam logic [2:0] SZ  = 3'b100;

  ahb_slave_ctrl_if bus0 ();
  ahb_slave_ctrl_if bus1 ();

  logic        hsel0, hsel1, hrdy0, hrdy1, hwrite, busy;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [2:0]  hsize;

  assign bus0.HSEL = hsel0;  assign bus1.HSEL = hsel1;
  assign bus0.HREADY = hrdy0; assign bus1.HREADY = hrdy1;
  assign bus0.HADDR = haddr;  assign bus1.HADDR = haddr;
  assign bus0.HTRANS = htrans; assign bus1.HTRANS = htrans;
  assign bus0.HWRITE = hwrite; assign bus1.HWRITE = hwrite;
  assign bus0.HSIZE = hsize;  assign bus1.HSIZE = hsize;
  assign bus0.core_busy = busy; assign bus1.core_busy = busy;

  ahb_slave_ctrl #(.RD_WAIT(2)) dut0 (.clk(clk), .n_rst(n_rst), .bus(bus0));
  ahb_slave_ctrl #(.RD_WAIT(0)) dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1));

  typedef struct {
    logic [4:0] e0;
    logic [4:0] e1;
    string      nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [4:0] a0, a1;
      e  = q.pop_front();
      a0 = {bus0.writek_enable, bus0.writed_enable, bus0.readd_enable,
            bus0.hresp_error, bus0.hready_enable};
      a1 = {bus1.writek_enable, bus1.writed_enable, bus1.readd_enable,
            bus1.hresp_error, bus1.hready_enable};
      checks++;
      if (a0 !== e.e0 || a1 !== e.e1) begin
        failures++;
        $display("FAIL %s: got dut0=%b dut1=%b expected dut0=%b dut1=%b",
                 e.nm, a0, a1, e.e0, e.e1);
      end
    end
  end

  // Inputs set here are sampled at the next edge; the expectation is for this cycle.
  task automatic cyc(input logic s0, input logic s1, input logic [1:0] tr,
                     input logic wr, input logic [7:0] a, input logic [2:0] sz,
                     input logic bz, input logic rst, input logic hz,
                     input logic [4:0] e0, input logic [4:0] e1, input string nm);
    exp_t e;
    @(posedge clk); #1;
    n_rst  = rst;
    hsel0  = s0;
    hsel1  = s1;
    htrans = tr;
    hwrite = wr;
    haddr  = {24'h0, a};
    hsize  = sz;
    busy   = bz;
    hrdy0  = e0[0] & ~hz;
    hrdy1  = e1[0] & ~hz;
    e.e0 = e0; e.e1 = e1; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic idle(input logic bz, input logic rst, input logic [4:0] e0,
                      input logic [4:0] e1, input string nm);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 8'h00, SZ, bz, rst, 1'b0, e0, e1, nm);
  endtask

  task automatic err_case(input logic wr, input logic [7:0] a, input logic [2:0] sz,
                          input string nm);
    cyc(1'b1, 1'b0, N, wr, a, sz, 1'b0, 1'b1, 1'b0, IDL, IDL, {nm, "_addr"});
    idle(1'b0, 1'b1, E1, IDL, {nm, "_err1"});
    idle(1'b0, 1'b1, E2, IDL, {nm, "_err2"});
    idle(1'b0, 1'b1, IDL, IDL, {nm, "_idle"});
  endtask

  initial begin
    n_rst = 1'b0; hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    haddr = '0; hsize = SZ; busy = 1'b0; hrdy0 = 1'b1; hrdy1 = 1'b1;
    @(posedge clk);

    idle(1'b0, 1'b0, IDL, IDL, "reset0");
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b1, IDL, IDL, "reset_idle");

    // Key write, then back-to-back data-in write
    cyc(1'b1, 1'b0, N, 1'b1, 8'h00, SZ, 1'b0, 1'b1, 1'b0, IDL, IDL, "kw_addr");
    cyc(1'b1, 1'b0, N, 1'b1, 8'h10, SZ, 1'b0, 1'b1, 1'b0, WK, IDL, "kw_data_b2b");
    idle(1'b0, 1'b1, WD, IDL, "wd_after_key");
    idle(1'b0, 1'b1, IDL, IDL, "wd_done");

    // Data-in write stalled 3 cycles by core_busy; key write pipelined on release
    cyc(1'b1, 1'b0, N, 1'b1, 8'h10, SZ, 1'b0, 1'b1, 1'b0, IDL, IDL, "stall_addr");
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b1, WDS, IDL, "stall_busy");
    cyc(1'b1, 1'b0, N, 1'b1, 8'h00, SZ, 1'b0, 1'b1, 1'b0, WD, IDL, "stall_release");
    idle(1'b0, 1'b1, WK, IDL, "key_after_stall");
    idle(1'b0, 1'b1, IDL, IDL, "stall_idle");

    // Read with RD_WAIT=2; core_busy ignored
    cyc(1'b1, 1'b0, N, 1'b0, 8'h20, SZ, 1'b0, 1'b1, 1'b0, IDL, IDL, "rd_addr");
    idle(1'b1, 1'b1, RW, IDL, "rd_wait1");
    idle(1'b1, 1'b1, RW, IDL, "rd_wait2");
    idle(1'b1, 1'b1, RD, IDL, "rd_done");
    idle(1'b0, 1'b1, IDL, IDL, "rd_idle");

    // Read with RD_WAIT=0 on the second instance
    cyc(1'b0, 1'b1, N, 1'b0, 8'h20, SZ, 1'b0, 1'b1, 1'b0, IDL, IDL, "rd0_addr");
    idle(1'b0, 1'b1, IDL, RD, "rd0_done");
    idle(1'b0, 1'b1, IDL, IDL, "rd0_idle");

    // Error responses
    err_case(1'b0, 8'h00, SZ, "err_rd_key");
    err_case(1'b1, 8'h20, SZ, "err_wr_dout");
    err_case(1'b1, 8'h44, SZ, "err_unmapped");
    // Wrong size presented during ERR2: pipelined straight into a new error
    cyc(1'b1, 1'b0, N, 1'b1, 8'h44, SZ, 1'b0, 1'b1, 1'b0, IDL, IDL, "err_b2b_addr");
    idle(1'b0, 1'b1, E1, IDL, "err_b2b_e1");
    cyc(1'b1, 1'b0, N, 1'b1, 8'h10, 3'b010, 1'b0, 1'b1, 1'b0, E2, IDL, "err_size_addr");
    idle(1'b0, 1'b1, E1, IDL, "err_size_e1");
    idle(1'b0, 1'b1, E2, IDL, "err_size_e2");
    idle(1'b0, 1'b1, IDL, IDL, "err_size_idle");

    // Non-transfers: BUSY, HSEL low, HREADY low; SEQ is a real transfer
    cyc(1'b1, 1'b0, 2'b01, 1'b1, 8'h00, SZ, 1'b0, 1'b1, 1'b0, IDL, IDL, "busy_addr");
    cyc(1'b0, 1'b0, N, 1'b1, 8'h00, SZ, 1'b0, 1'b1, 1'b0, IDL, IDL, "nosel_addr");
    cyc(1'b1, 1'b1, N, 1'b1, 8'h00, SZ, 1'b0, 1'b1, 1'b1, IDL, IDL, "hready_low_addr");
    cyc(1'b1, 1'b0, 2'b11, 1'b1, 8'h00, SZ, 1'b0, 1'b1, 1'b0, IDL, IDL, "seq_addr");
    idle(1'b0, 1'b1, WK, IDL, "seq_key");
    idle(1'b0, 1'b1, IDL, IDL, "seq_idle");

    // Reset in the second cycle of a read drops it
    cyc(1'b1, 1'b0, N, 1'b0, 8'h20, SZ, 1'b0, 1'b1, 1'b0, IDL, IDL, "rst_rd_addr");
    idle(1'b0, 1'b1, RW, IDL, "rst_rd_wait1");
    idle(1'b0, 1'b0, RW, IDL, "rst_rd_wait2");
    idle(1'b0, 1'b1, IDL, IDL, "rst_rd_after");
    idle(1'b0, 1'b1, IDL, IDL, "rst_rd_idle");

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
